// File: rtl/usb_sie_rx.sv
// USB full-speed SIE receiver: pin synchronizer, mid-bit clock recovery, NRZI decode,
// bit unstuffing and SYNC/EOP framing, delivering bytes on a UTMI-like interface.
module usb_sie_rx #(
  parameter int CLK_PER_BIT  = 4,
  parameter int STUFF_BITS_N = 6,
  parameter int SYNC_ZEROS_N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp_rx,
  input  logic       dn_rx,
  input  logic       tx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_BITS_N + 1);
  localparam int ZW = $clog2(SYNC_ZEROS_N + 1);
  localparam logic [PW-1:0] PHASE_MAX = PW'(CLK_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_MID = PW'(CLK_PER_BIT / 2 - 1);
  localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_BITS_N);
  localparam logic [ZW-1:0] ZERO_MIN  = ZW'(SYNC_ZEROS_N);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE_S = 3'd0,
    RX_SYNC_S = 3'd1,
    RX_DATA_S = 3'd2,
    RX_EOP_S  = 3'd3,
    RX_ERR_S  = 3'd4
  } state_t;

  state_t          state_r;
  logic            dp_meta_r, dp_sync_r, dn_meta_r, dn_sync_r;
  logic [1:0]      line_s;
  logic [1:0]      line_prev_r;
  logic [PW-1:0]   phase_r;
  logic            sample_s;
  logic [1:0]      samp_s;
  logic            dbit_s;
  logic [1:0]      nrzi_prev_r;
  logic [OW-1:0]   ones_cnt_r;
  logic [ZW-1:0]   zero_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [6:0]      shift_r;
  logic            err_seen_r;
  logic            se0_seen_r;
  logic [2:0]      j_cnt_r;

  // Two-flop synchronizers; reset to the idle J level so no edge is seen at startup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_meta_r <= 1'b1;
      dp_sync_r <= 1'b1;
      dn_meta_r <= 1'b0;
      dn_sync_r <= 1'b0;
    end else begin
      dp_meta_r <= dp_rx;
      dp_sync_r <= dp_meta_r;
      dn_meta_r <= dn_rx;
      dn_sync_r <= dn_meta_r;
    end
  end

  // Map synchronized pins to a line state; SE1 folds into SE0.
  always_comb begin
    case ({dn_sync_r, dp_sync_r})
      2'b01:   line_s = LS_J;
      2'b10:   line_s = LS_K;
      default: line_s = LS_SE0;
    endcase
  end

  // Phase counter realigns on every line edge and free-runs across runs of equal states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_prev_r <= LS_J;
      phase_r     <= '0;
    end else begin
      line_prev_r <= line_s;
      if (line_s != line_prev_r) begin
        phase_r <= '0;
      end else if (phase_r == PHASE_MAX) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PW'(1);
      end
    end
  end

  assign sample_s = (phase_r == PHASE_MID);
  assign samp_s   = line_prev_r;
  assign dbit_s   = (samp_s == nrzi_prev_r);

  // Receive FSM with NRZI history, unstuffer, byte assembly and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RX_IDLE_S;
      nrzi_prev_r <= LS_J;
      ones_cnt_r  <= '0;
      zero_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 7'd0;
      err_seen_r  <= 1'b0;
      se0_seen_r  <= 1'b0;
      j_cnt_r     <= 3'd0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      rx_active   <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (sample_s) begin
        nrzi_prev_r <= samp_s;
      end
      if (tx_active) begin
        state_r   <= RX_IDLE_S;
        rx_active <= 1'b0;
      end else if (sample_s) begin
        case (state_r)
          RX_IDLE_S: begin
            // The J->K edge that opens SYNC is consumed here, not counted as a zero.
            if (samp_s == LS_K && nrzi_prev_r == LS_J) begin
              state_r    <= RX_SYNC_S;
              zero_cnt_r <= '0;
              ones_cnt_r <= '0;
            end
          end
          RX_SYNC_S: begin
            if (samp_s == LS_SE0) begin
              state_r <= RX_IDLE_S;
            end else if (!dbit_s) begin
              ones_cnt_r <= '0;
              if (zero_cnt_r != ZERO_MIN) begin
                zero_cnt_r <= zero_cnt_r + ZW'(1);
              end
            end else if (zero_cnt_r >= ZERO_MIN) begin
              state_r    <= RX_DATA_S;
              rx_active  <= 1'b1;
              bit_cnt_r  <= 3'd0;
              ones_cnt_r <= OW'(1);
              err_seen_r <= 1'b0;
            end else begin
              state_r <= RX_IDLE_S;
            end
          end
          RX_DATA_S: begin
            if (samp_s == LS_SE0) begin
              state_r <= RX_EOP_S;
              if (bit_cnt_r != 3'd0) begin
                rx_error   <= 1'b1;
                err_seen_r <= 1'b1;
              end
            end else if (ones_cnt_r == STUFF_CNT) begin
              if (dbit_s) begin
                rx_error   <= 1'b1;
                err_seen_r <= 1'b1;
                state_r    <= RX_ERR_S;
                se0_seen_r <= 1'b0;
                j_cnt_r    <= 3'd0;
              end else begin
                ones_cnt_r <= '0;
              end
            end else begin
              shift_r    <= {dbit_s, shift_r[6:1]};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              ones_cnt_r <= dbit_s ? ones_cnt_r + OW'(1) : '0;
              if (bit_cnt_r == 3'd7) begin
                rx_data  <= {dbit_s, shift_r};
                rx_valid <= 1'b1;
              end
            end
          end
          RX_EOP_S: begin
            if (samp_s == LS_J) begin
              state_r   <= RX_IDLE_S;
              rx_active <= 1'b0;
            end else if (samp_s == LS_K) begin
              rx_error   <= !err_seen_r;
              err_seen_r <= 1'b1;
              state_r    <= RX_ERR_S;
              se0_seen_r <= 1'b0;
              j_cnt_r    <= 3'd0;
            end
          end
          RX_ERR_S: begin
            if (samp_s == LS_SE0) begin
              se0_seen_r <= 1'b1;
              j_cnt_r    <= 3'd0;
            end else if (samp_s == LS_J) begin
              if (se0_seen_r || j_cnt_r == 3'd7) begin
                state_r   <= RX_IDLE_S;
                rx_active <= 1'b0;
              end else begin
                j_cnt_r <= j_cnt_r + 3'd1;
              end
            end else begin
              se0_seen_r <= 1'b0;
              j_cnt_r    <= 3'd0;
            end
          end
          default: begin
            state_r   <= RX_IDLE_S;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
